rom: RTL and testbench



---
 rtl/rom_pkg.sv | 52 +++++
 rtl/rom_table.sv | 16 +
 rtl/rom.sv | 48 ++++
 tb/tb_rom.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared constants and content table for the 32 x 32 instruction ROM.
// Holds the boot/test program words and the rom_word() lookup used by rom_table.
package rom_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INSN = 32'h0000_0013;

    localparam logic [DATA_W-1:0] INSN_00 = 32'h0050_0093; // addi x1,x0,5
    localparam logic [DATA_W-1:0] INSN_01 = 32'h0030_0113; // addi x2,x0,3
    localparam logic [DATA_W-1:0] INSN_02 = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [DATA_W-1:0] INSN_03 = 32'h4020_8233; // sub  x4,x1,x2
    localparam logic [DATA_W-1:0] INSN_04 = 32'h0020_F2B3; // and  x5,x1,x2
    localparam logic [DATA_W-1:0] INSN_05 = 32'h0020_E333; // or   x6,x1,x2
    localparam logic [DATA_W-1:0] INSN_06 = 32'h0020_C3B3; // xor  x7,x1,x2
    localparam logic [DATA_W-1:0] INSN_07 = 32'h0020_9433; // sll  x8,x1,x2
    localparam logic [DATA_W-1:0] INSN_08 = 32'h0020_D4B3; // srl  x9,x1,x2
    localparam logic [DATA_W-1:0] INSN_09 = 32'h0030_2023; // sw   x3,0(x0)
    localparam logic [DATA_W-1:0] INSN_10 = 32'h0000_2503; // lw   x10,0(x0)
    localparam logic [DATA_W-1:0] INSN_11 = 32'h00A1_8463; // beq  x3,x10,+8
    localparam logic [DATA_W-1:0] INSN_12 = 32'h0010_0593; // addi x11,x0,1
    localparam logic [DATA_W-1:0] INSN_13 = 32'h0020_0613; // addi x12,x0,2
    localparam logic [DATA_W-1:0] INSN_14 = 32'h0080_06EF; // jal  x13,+8
    localparam logic [DATA_W-1:0] INSN_15 = 32'h0000_006F; // jal  x0,0 (halt loop)

    // Unknown or upper-half addresses fall into the default and return a NOP, never X.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] word;
        case (addr)
            5'd0:    word = INSN_00;
            5'd1:    word = INSN_01;
            5'd2:    word = INSN_02;
            5'd3:    word = INSN_03;
            5'd4:    word = INSN_04;
            5'd5:    word = INSN_05;
            5'd6:    word = INSN_06;
            5'd7:    word = INSN_07;
            5'd8:    word = INSN_08;
            5'd9:    word = INSN_09;
            5'd10:   word = INSN_10;
            5'd11:   word = INSN_11;
            5'd12:   word = INSN_12;
            5'd13:   word = INSN_13;
            5'd14:   word = INSN_14;
            5'd15:   word = INSN_15;
            default: word = NOP_INSN;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/rom_table.sv
// Combinational content lookup: word address to instruction word.
module rom_table
    import rom_pkg::*;
#(
    parameter int ADDR_W = rom_pkg::ADDR_W,
    parameter int DATA_W = rom_pkg::DATA_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);

    always_comb begin
        word = rom_word(addr);
    end

endmodule

// File: rtl/rom.sv
// Synchronous-read instruction ROM with one-cycle registered output.
// Optional ROM_PARITY_EN adds parity_out, the even parity of the loaded word.
module rom
    import rom_pkg::*;
#(
    parameter int ADDR_W = rom_pkg::ADDR_W,
    parameter int DATA_W = rom_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
`ifdef ROM_PARITY_EN
    ,
    output logic              parity_out
`endif
);

    logic [DATA_W-1:0] word_p0;

    rom_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_table (
        .addr (addr),
        .word (word_p0)
    );

    // p0 -> output register: every edge reloads, no enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= word_p0;
        end
    end

`ifdef ROM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_out <= 1'b0;
        end else begin
            parity_out <= ^word_p0;
        end
    end
`endif

endmodule

// File: tb/tb_rom.sv
// Self-checking bench for rom against an independent table of the boot program.
// Build with ROM_PARITY_EN defined to also cover parity_out.
module tb_rom;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
`ifdef ROM_PARITY_EN
    logic              parity_out;
`endif

    int tests;
    int fails;

    logic [DATA_W-1:0] ref_rom [32];

    rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_out (data_out)
`ifdef ROM_PARITY_EN
        ,
        .parity_out (parity_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic init_ref();
        logic [DATA_W-1:0] prog [16];
        prog = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h40208233,
                 32'h0020F2B3, 32'h0020E333, 32'h0020C3B3, 32'h00209433,
                 32'h0020D4B3, 32'h00302023, 32'h00002503, 32'h00A18463,
                 32'h00100593, 32'h00200613, 32'h008006EF, 32'h0000006F};
        for (int i = 0; i < 32; i++) begin
            ref_rom[i] = (i < 16) ? prog[i] : 32'h00000013;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        addr  = 5'd3;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (data_out !== 32'h0) begin
            fails++;
            $display("FAIL reset_async data_out=%08h expected=%08h", data_out, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (data_out !== 32'h0) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d data_out=%08h expected=%08h", i, data_out, 32'h0);
            end
`ifdef ROM_PARITY_EN
            tests++;
            if (parity_out !== 1'b0) begin
                fails++;
                $display("FAIL reset_parity cyc=%0d parity_out=%0b expected=0", i, parity_out);
            end
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (data_out !== ref_rom[3]) begin
            fails++;
            $display("FAIL reset_release data_out=%08h expected=%08h", data_out, ref_rom[3]);
        end
    endtask

    task automatic test_pkg_table();
        for (int i = 0; i < 32; i++) begin
            logic [DATA_W-1:0] w;
            w = rom_pkg::rom_word(5'(i));
            tests++;
            if (w !== ref_rom[i]) begin
                fails++;
                $display("FAIL pkg_word addr=%0d got=%08h expected=%08h", i, w, ref_rom[i]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests++;
                if (data_out !== ref_rom[i-1]) begin
                    fails++;
                    $display("FAIL sweep addr=%0d data_out=%08h expected=%08h", i-1, data_out, ref_rom[i-1]);
                end
            end
            if (i < 16) addr = 5'(i);
        end
    endtask

    task automatic test_upper();
        logic [ADDR_W-1:0] pts [3];
        pts = '{5'd16, 5'd23, 5'd31};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            addr = pts[i];
            @(negedge clk);
            tests++;
            if (data_out !== 32'h00000013) begin
                fails++;
                $display("FAIL upper addr=%0d data_out=%08h expected=%08h", pts[i], data_out, 32'h00000013);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        addr = 5'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (data_out !== 32'h002081B3) begin
                fails++;
                $display("FAIL hold cyc=%0d data_out=%08h expected=%08h", i, data_out, 32'h002081B3);
            end
        end
        addr = 5'd14;
        #1;
        tests++;
        if (data_out !== 32'h002081B3) begin
            fails++;
            $display("FAIL hold_pre_edge data_out=%08h expected=%08h", data_out, 32'h002081B3);
        end
        @(negedge clk);
        tests++;
        if (data_out !== 32'h008006EF) begin
            fails++;
            $display("FAIL hold_change data_out=%08h expected=%08h", data_out, 32'h008006EF);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] prev;
        @(negedge clk);
        prev = 5'($urandom_range(0, 31));
        addr = prev;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            tests++;
            if (data_out !== ref_rom[prev]) begin
                fails++;
                $display("FAIL random cyc=%0d addr=%0d data_out=%08h expected=%08h", i, prev, data_out, ref_rom[prev]);
            end
`ifdef ROM_PARITY_EN
            tests++;
            if (parity_out !== ^ref_rom[prev]) begin
                fails++;
                $display("FAIL random_parity cyc=%0d addr=%0d parity_out=%0b expected=%0b", i, prev, parity_out, ^ref_rom[prev]);
            end
`endif
            prev = 5'($urandom_range(0, 31));
            addr = prev;
        end
    endtask

`ifdef ROM_PARITY_EN
    task automatic test_parity();
        logic [ADDR_W-1:0] pts [2];
        pts = '{5'd0, 5'd2};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            addr = pts[i];
            @(negedge clk);
            tests++;
            if (parity_out !== ^ref_rom[pts[i]]) begin
                fails++;
                $display("FAIL parity addr=%0d parity_out=%0b expected=%0b", pts[i], parity_out, ^ref_rom[pts[i]]);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge clk);
        addr = 5'd1;
        @(negedge clk);
        tests++;
        if (data_out !== ref_rom[1]) begin
            fails++;
            $display("FAIL mid_pre data_out=%08h expected=%08h", data_out, ref_rom[1]);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (data_out !== 32'h0) begin
            fails++;
            $display("FAIL mid_async data_out=%08h expected=%08h", data_out, 32'h0);
        end
`ifdef ROM_PARITY_EN
        addr = 5'd2;
        @(negedge clk);
        tests++;
        if (parity_out !== 1'b0) begin
            fails++;
            $display("FAIL mid_parity parity_out=%0b expected=0", parity_out);
        end
`else
        @(negedge clk);
`endif
        rst_n = 1'b1;
        addr  = 5'd11;
        @(negedge clk);
        tests++;
        if (data_out !== ref_rom[11]) begin
            fails++;
            $display("FAIL mid_release data_out=%08h expected=%08h", data_out, ref_rom[11]);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        init_ref();
        test_reset();
        test_pkg_table();
        test_sweep();
        test_upper();
        test_hold();
        test_random();
`ifdef ROM_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
